// File: rtl/spi_master_n.sv
`default_nettype none
// =====================================================================
// spi_master_n : SPI master with programmable length, divider, mode,
//                bit order and registered chip selects.
// Revision     : 1.0
// =====================================================================
module spi_master_n #(
  parameter int W   = 16,
  parameter int NCS = 2,
  localparam int LW  = $clog2(W),
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic           clk,
  input  logic           resetq,
  input  logic           we,
  input  logic [W-1:0]   tx,
  input  logic [LW-1:0]  len,
  input  logic [7:0]     div,
  input  logic           cpol,
  input  logic           cpha,
  input  logic           lsbf,
  input  logic           hold,
  input  logic [CSW-1:0] cs_sel,
  output logic [W-1:0]   rx,
  output logic           busy,
  output logic           done,
  output logic           sclk,
  output logic           mosi,
  output logic [NCS-1:0] cs_n,
  input  logic           miso
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_TRAIL = 2'd3;

  // Edge counter must reach 2*W, hence two bits wider than len.
  localparam int EW = LW + 2;

  logic [1:0]     state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     div_q, div_d;
  logic [EW-1:0]  edge_q, edge_d;
  logic [LW-1:0]  len_q, len_d;
  logic           cpol_q, cpol_d;
  logic           cpha_q, cpha_d;
  logic           lsbf_q, lsbf_d;
  logic           hold_q, hold_d;
  logic [W-1:0]   tx_q, tx_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   rx_q, rx_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic           done_q, done_d;
  logic [NCS-1:0] cs_n_q, cs_n_d;

  logic           w_hp_end;
  logic           w_toggle;
  logic           w_sample;
  logic           w_last_edge;
  logic [EW-1:0]  w_nedges;
  logic [EW-1:0]  w_last_idx;
  logic [LW-1:0]  w_si;
  logic [LW-1:0]  w_j;
  logic [LW-1:0]  w_tx_pos;
  logic [LW-1:0]  w_rx_pos;
  logic [LW-1:0]  w_first_pos;

  assign w_hp_end    = (cnt_q == div_q);
  assign w_nedges    = {1'b0, len_q, 1'b0} + EW'(2);
  assign w_last_idx  = w_nedges - EW'(1);
  assign w_last_edge = (edge_q == w_last_idx);
  // Even edge indices are leading edges; cpha selects which role samples.
  assign w_sample    = (edge_q[0] == cpha_q);
  assign w_si        = edge_q[LW:1];
  // With cpha=0 bit 0 already went out on entry, so updates carry bit i+1.
  assign w_j         = w_si + (cpha_q ? {LW{1'b0}} : LW'(1));
  assign w_tx_pos    = lsbf_q ? w_j  : (len_q - w_j);
  assign w_rx_pos    = lsbf_q ? w_si : (len_q - w_si);
  assign w_first_pos = lsbf ? {LW{1'b0}} : len;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    edge_d   = edge_q;
    len_d    = len_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    lsbf_d   = lsbf_q;
    hold_d   = hold_q;
    tx_d     = tx_q;
    acc_d    = acc_q;
    rx_d     = rx_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    done_d   = 1'b0;
    w_toggle = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!hold_q) begin
          cs_n_d = '1;
        end
        if (we) begin
          len_d   = len;
          div_d   = div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsbf_d  = lsbf;
          hold_d  = hold;
          tx_d    = tx;
          acc_d   = '0;
          cnt_d   = 8'd0;
          edge_d  = '0;
          sclk_d  = cpol;
          cs_n_d  = ~(NCS'(1) << cs_sel);
          if (!cpha) begin
            mosi_d = tx[w_first_pos];
          end
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (w_hp_end) begin
          cnt_d    = 8'd0;
          w_toggle = 1'b1;
          state_d  = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (w_hp_end) begin
          cnt_d = 8'd0;
          if (edge_q == w_nedges) begin
            rx_d    = acc_q;
            state_d = S_TRAIL;
          end else begin
            w_toggle = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (w_hp_end) begin
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    if (w_toggle) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + EW'(1);
      if (w_sample) begin
        acc_d[w_rx_pos] = miso;
      end else if (cpha_q || !w_last_edge) begin
        mosi_d = tx_q[w_tx_pos];
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      div_q   <= 8'd0;
      edge_q  <= '0;
      len_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsbf_q  <= 1'b0;
      hold_q  <= 1'b0;
      tx_q    <= '0;
      acc_q   <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      len_q   <= len_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsbf_q  <= lsbf_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      acc_q   <= acc_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign rx   = rx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;

endmodule
`default_nettype wire
